sdram_line_writer: RTL and testbench

- Upstream feeder for the SDRAM burst-write engine. Collects 32-bit store words from the CPU/memory port into full SDRAM lines of 8x16-bit beats, using two ping-pong line buffers.
- Maps the byte address onto row/bank/column and issues one write request per full line. Holds address and data stable until the engine reports finish.

---
 rtl/sdram_line_writer_pkg.sv | 39 +++
 rtl/sdram_line_buf.sv | 74 +++++++
 rtl/sdram_line_writer.sv | 139 +++++++++++++
 tb/tb_sdram_line_writer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_line_writer_pkg.sv
// Shared constants for the SDRAM line writer: bus/line geometry, address
// field positions, buffer and drain-FSM state encodings, line tag layout.
// Ports: none (package).
package sdram_line_writer_pkg;

  localparam int DQ_W     = 16;
  localparam int BEATS    = 8;
  localparam int LINE_W   = DQ_W * BEATS;
  localparam int WORD_W   = 32;
  localparam int WPL      = LINE_W / WORD_W;
  localparam int ADDR_W   = 26;

  localparam int ROW_LSB  = 13;
  localparam int BANK_LSB = 11;
  localparam int COL_LSB  = 4;

  // Line buffer states
  localparam logic [1:0] LW_EMPTY   = 2'd0;
  localparam logic [1:0] LW_FILLING = 2'd1;
  localparam logic [1:0] LW_FULL    = 2'd2;

  // Drain FSM states
  localparam logic [1:0] LW_IDLE = 2'd0;
  localparam logic [1:0] LW_REQ  = 2'd1;
  localparam logic [1:0] LW_WAIT = 2'd2;

  // Line identity: everything above the word index, i.e. addr[25:4]
  typedef struct packed {
    logic [ADDR_W-ROW_LSB-1:0]   row;
    logic [ROW_LSB-BANK_LSB-1:0] bank;
    logic [BANK_LSB-COL_LSB-1:0] col;
  } line_tag_t;

  // Low halfword goes out first on the DQ bus, so it lands in the upper half
  function automatic logic [WORD_W-1:0] place_word(input logic [WORD_W-1:0] d);
    return {d[DQ_W-1:0], d[WORD_W-1:DQ_W]};
  endfunction

endpackage

// File: rtl/sdram_line_buf.sv
// One SDRAM line buffer: tag, 4-bit word valid mask, 128-bit line data and
// EMPTY/FILLING/FULL state. Writes land on the rising edge of iclk.
// Ports: iwr_i/itag_i/iidx_i/idata_i write a word, iclr_i empties the buffer,
//        ostate_o/otag_o/odata_o expose contents, omatch_o says a word for
//        itag_i may be written, odone_o flags the write that completes the line.
module sdram_line_buf
  import sdram_line_writer_pkg::*;
(
  input  logic              iclk,
  input  logic              ctr_reset,
  input  logic              iwr_i,
  input  line_tag_t         itag_i,
  input  logic [1:0]        iidx_i,
  input  logic [WORD_W-1:0] idata_i,
  input  logic              iclr_i,
  output logic [1:0]        ostate_o,
  output line_tag_t         otag_o,
  output logic [LINE_W-1:0] odata_o,
  output logic              omatch_o,
  output logic              odone_o
);

  logic [1:0]        state_q, state_d;
  line_tag_t         tag_q, tag_d;
  logic [WPL-1:0]    mask_q, mask_d;
  logic [LINE_W-1:0] data_q, data_d;
  logic [WPL-1:0]    bit_w;
  logic [WPL-1:0]    mask_set;

  assign bit_w    = {{(WPL-1){1'b0}}, 1'b1} << iidx_i;
  // A fresh line starts from an empty mask regardless of stale contents
  assign mask_set = (state_q == LW_EMPTY) ? bit_w : (mask_q | bit_w);

  assign omatch_o = (state_q == LW_EMPTY) ||
                    ((state_q == LW_FILLING) && (tag_q == itag_i));
  assign odone_o  = iwr_i && (mask_set == {WPL{1'b1}});

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    mask_d  = mask_q;
    data_d  = data_q;
    if (iclr_i) begin
      state_d = LW_EMPTY;
      mask_d  = '0;
    end else if (iwr_i) begin
      if (state_q == LW_EMPTY) tag_d = itag_i;
      mask_d = mask_set;
      for (int w = 0; w < WPL; w++) begin
        if (iidx_i == 2'(w)) data_d[LINE_W-1-WORD_W*w -: WORD_W] = place_word(idata_i);
      end
      state_d = (mask_set == {WPL{1'b1}}) ? LW_FULL : LW_FILLING;
    end
  end

  always_ff @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset) begin
      state_q <= LW_EMPTY;
      tag_q   <= '0;
      mask_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
    end
  end

  assign ostate_o = state_q;
  assign otag_o   = tag_q;
  assign odata_o  = data_q;

endmodule

// File: rtl/sdram_line_writer.sv
// Collects 32-bit CPU stores into 128-bit SDRAM lines in two ping-pong buffers
// and hands each full line to the burst-write engine (oreq/oenb/ifin).
// Ports: iwr_* / oready / oerr on the CPU side; ibusy, oreq, oenb, ifin and
//        orow/obank/ocolumn/odata on the engine side; oidle when fully drained.
module sdram_line_writer
  import sdram_line_writer_pkg::*;
(
  input  logic              iclk,
  input  logic              ctr_reset,
  input  logic              iwr_valid,
  output logic              oready,
  input  logic [ADDR_W-1:0] iwr_addr,
  input  logic [WORD_W-1:0] iwr_data,
  output logic              oerr,
  input  logic              ibusy,
  output logic              oreq,
  output logic              oenb,
  input  logic              ifin,
  output logic [12:0]       orow,
  output logic [1:0]        obank,
  output logic [9:0]        ocolumn,
  output logic [LINE_W-1:0] odata,
  output logic              oidle
);

  line_tag_t         wtag;
  logic [1:0]        widx;
  logic              unused_addr;

  logic [1:0]        b_state [2];
  line_tag_t         b_tag   [2];
  logic [LINE_W-1:0] b_data  [2];
  logic              b_match [2];
  logic              b_done  [2];
  logic              b_wr    [2];
  logic              b_clr   [2];

  logic              fsel_q, fsel_d, dsel_q, dsel_d;
  logic [1:0]        st_q, st_d;
  logic              err_q;
  logic              load;
  logic              accept, fin_evt, fill_full_nx, other_empty_nx;
  logic [12:0]       row_q;
  logic [1:0]        bank_q;
  logic [9:0]        col_q;
  logic [LINE_W-1:0] data_q;

  assign wtag        = line_tag_t'(iwr_addr[ADDR_W-1:COL_LSB]);
  assign widx        = iwr_addr[COL_LSB-1:2];
  assign unused_addr = ^iwr_addr[1:0];

  for (genvar g = 0; g < 2; g++) begin : g_buf
    sdram_line_buf u_buf (
      .iclk     (iclk),
      .ctr_reset(ctr_reset),
      .iwr_i    (b_wr[g]),
      .itag_i   (wtag),
      .iidx_i   (widx),
      .idata_i  (iwr_data),
      .iclr_i   (b_clr[g]),
      .ostate_o (b_state[g]),
      .otag_o   (b_tag[g]),
      .odata_o  (b_data[g]),
      .omatch_o (b_match[g]),
      .odone_o  (b_done[g])
    );
  end

  assign oready  = (b_state[fsel_q] != LW_FULL);
  assign accept  = iwr_valid && oready;
  assign fin_evt = (st_q == LW_WAIT) && ifin;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      b_wr[i]  = accept && (fsel_q == 1'(i)) && b_match[i];
      b_clr[i] = fin_evt && (dsel_q == 1'(i));
    end
  end

  // Move filling to the other buffer as soon as this one is (or becomes) full
  // and the other one is (or is being made) empty, so a freed buffer is
  // usable on the very next cycle.
  assign fill_full_nx   = (b_state[fsel_q] == LW_FULL) || b_done[fsel_q];
  assign other_empty_nx = (b_state[~fsel_q] == LW_EMPTY) || (fin_evt && (dsel_q != fsel_q));
  assign fsel_d         = fsel_q ^ (fill_full_nx && other_empty_nx);

  always_comb begin
    st_d   = st_q;
    dsel_d = dsel_q;
    load   = 1'b0;
    case (st_q)
      LW_IDLE: if ((b_state[dsel_q] == LW_FULL) && !ibusy) begin
        st_d = LW_REQ;
        load = 1'b1;
      end
      LW_REQ:  st_d = LW_WAIT;
      LW_WAIT: if (ifin) begin
        st_d   = LW_IDLE;
        dsel_d = ~dsel_q;
      end
      default: st_d = LW_IDLE;
    endcase
  end

  always_ff @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset) begin
      fsel_q <= 1'b0;
      dsel_q <= 1'b0;
      st_q   <= LW_IDLE;
      err_q  <= 1'b0;
      row_q  <= '0;
      bank_q <= '0;
      col_q  <= '0;
      data_q <= '0;
    end else begin
      fsel_q <= fsel_d;
      dsel_q <= dsel_d;
      st_q   <= st_d;
      err_q  <= accept && !b_match[fsel_q];
      // Engine-facing address/data are captured once and frozen until ifin
      if (load) begin
        row_q  <= b_tag[dsel_q].row;
        bank_q <= b_tag[dsel_q].bank;
        col_q  <= {b_tag[dsel_q].col, 3'b000};
        data_q <= b_data[dsel_q];
      end
    end
  end

  assign oerr    = err_q;
  assign oreq    = (st_q == LW_REQ);
  assign oenb    = (st_q != LW_IDLE);
  assign orow    = row_q;
  assign obank   = bank_q;
  assign ocolumn = col_q;
  assign odata   = data_q;
  assign oidle   = (b_state[0] == LW_EMPTY) && (b_state[1] == LW_EMPTY) && (st_q == LW_IDLE);

endmodule

// File: tb/tb_sdram_line_writer.sv
module tb_sdram_line_writer;

  logic         iclk = 1'b0;
  logic         ctr_reset = 1'b1;
  logic         iwr_valid = 1'b0;
  logic         oready;
  logic [25:0]  iwr_addr = '0;
  logic [31:0]  iwr_data = '0;
  logic         oerr;
  logic         ibusy = 1'b0;
  logic         oreq;
  logic         oenb;
  logic         ifin = 1'b0;
  logic [12:0]  orow;
  logic [1:0]   obank;
  logic [9:0]   ocolumn;
  logic [127:0] odata;
  logic         oidle;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 iclk = ~iclk;

  sdram_line_writer dut (
    .iclk     (iclk),
    .ctr_reset(ctr_reset),
    .iwr_valid(iwr_valid),
    .oready   (oready),
    .iwr_addr (iwr_addr),
    .iwr_data (iwr_data),
    .oerr     (oerr),
    .ibusy    (ibusy),
    .oreq     (oreq),
    .oenb     (oenb),
    .ifin     (ifin),
    .orow     (orow),
    .obank    (obank),
    .ocolumn  (ocolumn),
    .odata    (odata),
    .oidle    (oidle)
  );

  typedef struct packed {
    logic [3:0][25:0] addr;
    logic [3:0][31:0] data;
    logic [12:0]      row;
    logic [1:0]       bank;
    logic [9:0]       col;
    logic [127:0]     line;
  } vec_t;

  vec_t vecs [3];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Entered at a negedge; drives one word across the next rising edge.
  task automatic put(input logic [25:0] a, input logic [31:0] d);
    iwr_valid = 1'b1;
    iwr_addr  = a;
    iwr_data  = d;
    @(negedge iclk);
  endtask

  task automatic finish_burst();
    ifin = 1'b1;
    @(negedge iclk);
    ifin = 1'b0;
    chk("oenb_after_fin", 128'(oenb), 128'd0);
  endtask

  task automatic run_vec(input vec_t v, input int n);
    for (int i = 0; i < 4; i++) put(v.addr[i], v.data[i]);
    iwr_valid = 1'b0;
    chk($sformatf("v%0d_oreq_early", n), 128'(oreq), 128'd0);
    @(negedge iclk);
    chk($sformatf("v%0d_oreq", n), 128'(oreq), 128'd1);
    chk($sformatf("v%0d_oenb", n), 128'(oenb), 128'd1);
    chk($sformatf("v%0d_row", n), 128'(orow), 128'(v.row));
    chk($sformatf("v%0d_bank", n), 128'(obank), 128'(v.bank));
    chk($sformatf("v%0d_col", n), 128'(ocolumn), 128'(v.col));
    chk($sformatf("v%0d_data", n), odata, v.line);
    @(negedge iclk);
    chk($sformatf("v%0d_oreq_once", n), 128'(oreq), 128'd0);
    chk($sformatf("v%0d_oenb_wait", n), 128'(oenb), 128'd1);
    finish_burst();
    chk($sformatf("v%0d_oidle", n), 128'(oidle), 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Line at 0, words in order
    vecs[0].addr = {26'h000000C, 26'h0000008, 26'h0000004, 26'h0000000};
    vecs[0].data = {32'h77778888, 32'h55556666, 32'h33334444, 32'h11112222};
    vecs[0].row  = 13'h0000;
    vecs[0].bank = 2'd0;
    vecs[0].col  = 10'h000;
    vecs[0].line = 128'h2222_1111_4444_3333_6666_5555_8888_7777;
    // Top of the address space
    vecs[1].addr = {26'h3FFFFFC, 26'h3FFFFF8, 26'h3FFFFF4, 26'h3FFFFF0};
    vecs[1].data = {32'h89ABCDEF, 32'h01234567, 32'hCAFEF00D, 32'hDEADBEEF};
    vecs[1].row  = 13'h1FFF;
    vecs[1].bank = 2'd3;
    vecs[1].col  = 10'h3F8;
    vecs[1].line = 128'hBEEF_DEAD_F00D_CAFE_4567_0123_CDEF_89AB;
    // Row 0xAB, bank 2, col 0x2A8; arrival order w=3,1,0,2
    vecs[2].addr = {26'h0157558, 26'h0157550, 26'h0157554, 26'h015755C};
    vecs[2].data = {32'hDDDD2222, 32'hCCCC0000, 32'hBBBB1111, 32'hAAAA3333};
    vecs[2].row  = 13'h00AB;
    vecs[2].bank = 2'd2;
    vecs[2].col  = 10'h2A8;
    vecs[2].line = 128'h0000_CCCC_1111_BBBB_2222_DDDD_3333_AAAA;

    repeat (2) @(negedge iclk);
    chk("rst_oenb_in_reset", 128'(oenb), 128'd0);
    ctr_reset = 1'b0;
    @(negedge iclk);
    chk("rst_oready", 128'(oready), 128'd1);
    chk("rst_oerr", 128'(oerr), 128'd0);
    chk("rst_oreq", 128'(oreq), 128'd0);
    chk("rst_oenb", 128'(oenb), 128'd0);
    chk("rst_orow", 128'(orow), 128'd0);
    chk("rst_obank", 128'(obank), 128'd0);
    chk("rst_ocolumn", 128'(ocolumn), 128'd0);
    chk("rst_odata", odata, 128'd0);
    chk("rst_oidle", 128'(oidle), 128'd1);

    for (int n = 0; n < 3; n++) run_vec(vecs[n], n);

    // Engine stalls on line A while line B fills; 9th word must be held off
    for (int i = 0; i < 4; i++) put(26'h0000400 + 26'(4*i), 32'hA000_0000 + 32'(i));
    for (int i = 0; i < 4; i++) put(26'h0000800 + 26'(4*i), 32'hB000_0000 + 32'(i));
    chk("stall_oenb", 128'(oenb), 128'd1);
    chk("stall_oready", 128'(oready), 128'd0);
    put(26'h0000C00, 32'h9999_9999);
    iwr_valid = 1'b0;
    chk("stall_oready_held", 128'(oready), 128'd0);
    chk("stall_no_err", 128'(oerr), 128'd0);
    ifin = 1'b1;
    @(negedge iclk);
    ifin = 1'b0;
    chk("swap_oready", 128'(oready), 128'd1);
    chk("swap_oreq_idle", 128'(oreq), 128'd0);
    @(negedge iclk);
    chk("b_oreq", 128'(oreq), 128'd1);
    chk("b_bank", 128'(obank), 128'd1);
    chk("b_col", 128'(ocolumn), 128'd0);
    chk("b_data", odata, 128'h0000B000_0001B000_0002B000_0003B000);
    @(negedge iclk);
    finish_burst();
    chk("b_oidle", 128'(oidle), 128'd1);

    // Line mismatch drops the word without disturbing the partial line
    put(26'h0000100, 32'h0000_0001);
    put(26'h0000104, 32'h0000_0002);
    put(26'h0000200, 32'hFFFF_FFFF);
    chk("err_pulse", 128'(oerr), 128'd1);
    chk("err_oready", 128'(oready), 128'd1);
    put(26'h0000108, 32'h0000_0003);
    chk("err_one_cycle", 128'(oerr), 128'd0);
    put(26'h000010C, 32'h0000_0004);
    iwr_valid = 1'b0;
    @(negedge iclk);
    chk("err_line_oreq", 128'(oreq), 128'd1);
    chk("err_line_col", 128'(ocolumn), 128'h080);
    chk("err_line_data", odata, 128'h0001_0000_0002_0000_0003_0000_0004_0000);
    @(negedge iclk);
    finish_burst();

    // ibusy holds off the request; reset in WAIT abandons the burst
    ibusy = 1'b1;
    for (int i = 0; i < 4; i++) put(26'h0001000 + 26'(4*i), 32'hC000_0000 + 32'(i));
    iwr_valid = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge iclk);
        seen = seen | oreq;
      end
      chk("busy_no_oreq", 128'(seen), 128'd0);
    end
    chk("busy_not_idle", 128'(oidle), 128'd0);
    ibusy = 1'b0;
    @(negedge iclk);
    chk("busy_oreq", 128'(oreq), 128'd1);
    chk("busy_bank", 128'(obank), 128'd2);
    @(negedge iclk);
    ibusy = 1'b1;
    @(negedge iclk);
    chk("wait_ignores_busy", 128'(oenb), 128'd1);
    ctr_reset = 1'b1;
    #1;
    chk("mid_rst_oenb", 128'(oenb), 128'd0);
    chk("mid_rst_oreq", 128'(oreq), 128'd0);
    chk("mid_rst_oready", 128'(oready), 128'd1);
    chk("mid_rst_oidle", 128'(oidle), 128'd1);
    chk("mid_rst_obank", 128'(obank), 128'd0);
    chk("mid_rst_odata", odata, 128'd0);
    @(negedge iclk);
    ctr_reset = 1'b0;
    ibusy = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge iclk);
        seen = seen | oreq;
      end
      chk("no_retry", 128'(seen), 128'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
